// File: rtl/sobel_gradient_pipe_if.sv
// Stream interface for sobel_gradient_pipe: window/mode/thresh input channel,
// gradient/pixel output channel, and the edge-counter clear and readout.
interface sobel_gradient_pipe_if #(
    parameter int PIX_W = 8,
    parameter int CNT_W = 20
);
    localparam int GW = PIX_W + 3;

    logic [9*PIX_W-1:0]   window;
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           mode;
    logic [GW-1:0]        thresh;

    logic                 out_valid;
    logic                 out_ready;
    logic signed [GW-1:0] gx_out;
    logic signed [GW-1:0] gy_out;
    logic [GW-1:0]        mag_out;
    logic [PIX_W-1:0]     pix_out;

    logic                 cnt_clr;
    logic [CNT_W-1:0]     edge_cnt;

    modport slave (
        input  window, in_valid, mode, thresh, out_ready, cnt_clr,
        output in_ready, out_valid, gx_out, gy_out, mag_out, pix_out, edge_cnt
    );

    modport master (
        output window, in_valid, mode, thresh, out_ready, cnt_clr,
        input  in_ready, out_valid, gx_out, gy_out, mag_out, pix_out, edge_cnt
    );
endinterface

// File: rtl/sobel_gradient_pipe.sv
// Three-stage Sobel engine: S1 gradients, S2 magnitude/compare, S3 output registers,
// plus a saturating count of transferred outputs whose |gx|+|gy| exceeds thresh.
module sobel_gradient_pipe #(
    parameter int PIX_W = 8,
    parameter int CNT_W = 20
) (
    input  logic                 clk,
    input  logic                 n_rst,
    sobel_gradient_pipe_if.slave bus
);
    localparam int               GW      = PIX_W + 3;
    localparam logic [GW-1:0]    PIX_MAX = GW'((1 << PIX_W) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Valid/ready: a transfer happens on any edge where valid and ready are both high.
    // out_valid never drops before its transfer; every stage advances together unless
    // the output is stalled (out_valid & ~out_ready), and in_ready is exactly ~stall.

    logic                 r_s1_valid;
    logic signed [GW-1:0] r_s1_gx;
    logic signed [GW-1:0] r_s1_gy;
    logic [1:0]           r_s1_mode;
    logic [GW-1:0]        r_s1_thresh;

    logic                 r_s2_valid;
    logic signed [GW-1:0] r_s2_gx;
    logic signed [GW-1:0] r_s2_gy;
    logic [GW-1:0]        r_s2_mag;
    logic                 r_s2_edge;
    logic [1:0]           r_s2_mode;

    logic                 r_s3_valid;
    logic signed [GW-1:0] r_gx_out;
    logic signed [GW-1:0] r_gy_out;
    logic [GW-1:0]        r_mag_out;
    logic [PIX_W-1:0]     r_pix_out;
    logic                 r_s3_edge;

    logic [CNT_W-1:0]     r_edge_cnt;

    logic                 w_stall;
    logic                 w_adv;
    logic signed [GW-1:0] w_px [9];
    logic signed [GW-1:0] w_gx;
    logic signed [GW-1:0] w_gy;
    logic [GW-1:0]        w_abs_gx;
    logic [GW-1:0]        w_abs_gy;
    logic [GW-1:0]        w_sum;
    logic [GW-1:0]        w_mag;
    logic [PIX_W-1:0]     w_pix;
    logic                 w_xfer;

    assign w_stall = r_s3_valid & ~bus.out_ready;
    assign w_adv   = ~w_stall;
    assign w_xfer  = r_s3_valid & bus.out_ready;

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            w_px[i] = $signed({3'b000, bus.window[i*PIX_W +: PIX_W]});
        end
    end

    // GW bits hold the full +/-4*(2^PIX_W-1) range, so modular intermediates are exact.
    assign w_gx = (w_px[2] - w_px[0]) + ((w_px[5] - w_px[3]) <<< 1) + (w_px[8] - w_px[6]);
    assign w_gy = (w_px[6] + (w_px[7] <<< 1) + w_px[8]) - (w_px[0] + (w_px[1] <<< 1) + w_px[2]);

    assign w_abs_gx = r_s1_gx[GW-1] ? -r_s1_gx : r_s1_gx;
    assign w_abs_gy = r_s1_gy[GW-1] ? -r_s1_gy : r_s1_gy;
    assign w_sum    = w_abs_gx + w_abs_gy;

    always_comb begin
        w_mag = w_sum;
        case (r_s1_mode)
            2'b00:   w_mag = w_abs_gx;
            2'b01:   w_mag = w_abs_gy;
            default: w_mag = w_sum;
        endcase
    end

    always_comb begin
        w_pix = r_s2_mag[PIX_W-1:0];
        if (r_s2_mode == 2'b11) begin
            w_pix = r_s2_edge ? '1 : '0;
        end else if (r_s2_mag > PIX_MAX) begin
            w_pix = '1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_gx     <= '0;
            r_s1_gy     <= '0;
            r_s1_mode   <= '0;
            r_s1_thresh <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_gx     <= '0;
            r_s2_gy     <= '0;
            r_s2_mag    <= '0;
            r_s2_edge   <= 1'b0;
            r_s2_mode   <= '0;
            r_s3_valid  <= 1'b0;
            r_gx_out    <= '0;
            r_gy_out    <= '0;
            r_mag_out   <= '0;
            r_pix_out   <= '0;
            r_s3_edge   <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_gx     <= w_gx;
                r_s1_gy     <= w_gy;
                r_s1_mode   <= bus.mode;
                r_s1_thresh <= bus.thresh;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_gx   <= r_s1_gx;
                r_s2_gy   <= r_s1_gy;
                r_s2_mag  <= w_mag;
                r_s2_edge <= (w_sum > r_s1_thresh);
                r_s2_mode <= r_s1_mode;
            end
            // Output fields only change when a real window lands, so bubbles leave them intact.
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_gx_out  <= r_s2_gx;
                r_gy_out  <= r_s2_gy;
                r_mag_out <= r_s2_mag;
                r_pix_out <= w_pix;
                r_s3_edge <= r_s2_edge;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_edge_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_edge_cnt <= '0;
        end else if (w_xfer && r_s3_edge && (r_edge_cnt != CNT_MAX)) begin
            r_edge_cnt <= r_edge_cnt + 1'b1;
        end
    end

    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_s3_valid;
    assign bus.gx_out    = r_gx_out;
    assign bus.gy_out    = r_gy_out;
    assign bus.mag_out   = r_mag_out;
    assign bus.pix_out   = r_pix_out;
    assign bus.edge_cnt  = r_edge_cnt;
endmodule

// File: tb/tb_sobel_gradient_pipe.sv
// Bench for sobel_gradient_pipe: randomized windows against an integer Sobel model,
// with a queue-based scoreboard drained by an independent output monitor.
module tb_sobel_gradient_pipe;
    localparam int PIX_W = 8;
    localparam int CNT_W = 4;
    localparam int GW    = PIX_W + 3;
    localparam int PMAX  = (1 << PIX_W) - 1;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic signed [GW-1:0] gx;
        logic signed [GW-1:0] gy;
        logic [GW-1:0]        mag;
        logic [PIX_W-1:0]     pix;
        logic                 edge_hit;
    } exp_t;
    localparam int EW = $bits(exp_t);

    logic          clk;
    logic          n_rst;
    int            n_checks = 0;
    int            n_pass   = 0;
    int            exp_cnt  = 0;
    int            bp_mode  = 0;
    logic [EW-1:0] exp_q[$];

    sobel_gradient_pipe_if #(.PIX_W(PIX_W), .CNT_W(CNT_W)) bus ();

    sobel_gradient_pipe #(.PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- output backpressure ----------------
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: straight integer arithmetic on the nine pixels.
    function automatic exp_t model(input logic [9*PIX_W-1:0] w, input logic [1:0] m,
                                   input logic [GW-1:0] t);
        int   p[9];
        int   gx, gy, ax, ay, s, mag, pix, thr;
        exp_t e;
        for (int i = 0; i < 9; i++) p[i] = int'(w[i*PIX_W +: PIX_W]);
        thr = int'(t);
        gx  = (p[2] - p[0]) + 2 * (p[5] - p[3]) + (p[8] - p[6]);
        gy  = (p[6] + 2 * p[7] + p[8]) - (p[0] + 2 * p[1] + p[2]);
        ax  = (gx < 0) ? -gx : gx;
        ay  = (gy < 0) ? -gy : gy;
        s   = ax + ay;
        mag = (m == 2'b00) ? ax : (m == 2'b01) ? ay : s;
        if (m == 2'b11) pix = (s > thr) ? PMAX : 0;
        else            pix = (mag > PMAX) ? PMAX : mag;
        e.gx       = GW'(gx);
        e.gy       = GW'(gy);
        e.mag      = GW'(mag);
        e.pix      = PIX_W'(pix);
        e.edge_hit = (s > thr);
        return e;
    endfunction

    function automatic logic [9*PIX_W-1:0] mkwin(input int a0, input int a1, input int a2,
                                                 input int a3, input int a4, input int a5,
                                                 input int a6, input int a7, input int a8);
        logic [9*PIX_W-1:0] w;
        w = {PIX_W'(a8), PIX_W'(a7), PIX_W'(a6), PIX_W'(a5), PIX_W'(a4),
             PIX_W'(a3), PIX_W'(a2), PIX_W'(a1), PIX_W'(a0)};
        return w;
    endfunction

    function automatic logic [9*PIX_W-1:0] rand_win();
        logic [9*PIX_W-1:0] w;
        for (int i = 0; i < 9; i++) begin
            case ($urandom_range(0, 5))
                0:       w[i*PIX_W +: PIX_W] = '0;
                1:       w[i*PIX_W +: PIX_W] = '1;
                default: w[i*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, PMAX));
            endcase
        end
        return w;
    endfunction

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic send(input logic [9*PIX_W-1:0] w, input logic [1:0] m, input logic [GW-1:0] t);
        logic acc;
        bit   done;
        int   guard;
        done  = 1'b0;
        guard = 0;
        bus.window   = w;
        bus.mode     = m;
        bus.thresh   = t;
        bus.in_valid = 1'b1;
        while (!done) begin
            #1;
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                exp_q.push_back(model(w, m, t));
                done = 1'b1;
            end else begin
                guard++;
                if (guard > 500) begin
                    chk("send_timeout", 0, 1);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        logic xfer;
        if (!n_rst) begin
            exp_cnt = 0;
        end else begin
            chk("edge_cnt", bus.edge_cnt, exp_cnt);
            xfer = bus.out_valid & bus.out_ready;
            e    = '0;
            if (xfer) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("gx_out", bus.gx_out, e.gx);
                    chk("gy_out", bus.gy_out, e.gy);
                    chk("mag_out", bus.mag_out, e.mag);
                    chk("pix_out", bus.pix_out, e.pix);
                end
            end
            if (bus.cnt_clr) exp_cnt = 0;
            else if (xfer && e.edge_hit && exp_cnt < CMAX) exp_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin : main
        exp_t h;
        bit   found;
        bus.window   = '0;
        bus.mode     = 2'b00;
        bus.thresh   = '0;
        bus.in_valid = 1'b0;
        bus.cnt_clr  = 1'b0;
        n_rst        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_gx", bus.gx_out, 0);
        chk("reset_gy", bus.gy_out, 0);
        chk("reset_mag", bus.mag_out, 0);
        chk("reset_pix", bus.pix_out, 0);
        chk("reset_cnt", bus.edge_cnt, 0);
        n_rst = 1'b1;
        #1;
        chk("reset_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Flat window plus latency: valid appears after the third edge counting the accept.
        send(mkwin(100, 100, 100, 100, 100, 100, 100, 100, 100), 2'b10, GW'(0));
        bus.in_valid = 1'b0;
        chk("lat_edge1", bus.out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_edge2", bus.out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_edge3", bus.out_valid, 1);
        idle(2);

        send(mkwin(0, 128, 255, 0, 128, 255, 0, 128, 255), 2'b00, GW'(0));
        send(mkwin(255, 128, 0, 255, 128, 0, 255, 128, 0), 2'b00, GW'(0));
        send(mkwin(10, 10, 10, 30, 30, 30, 50, 50, 50), 2'b11, GW'(150));
        send(mkwin(10, 10, 10, 30, 30, 30, 50, 50, 50), 2'b11, GW'(160));
        idle(8);

        // Back-to-back stream with a 4-cycle output stall.
        fork
            begin
                for (int k = 0; k < 8; k++)
                    send(rand_win(), 2'($urandom_range(0, 3)), GW'($urandom_range(0, 400)));
                bus.in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                bp_mode = 2;
                repeat (4) begin
                    @(posedge clk);
                    #2;
                    chk("stall_in_ready", bus.in_ready, 0);
                    chk("stall_out_valid", bus.out_valid, 1);
                    if (exp_q.size() != 0) begin
                        h = exp_q[0];
                        chk("stall_hold_gx", bus.gx_out, h.gx);
                        chk("stall_hold_mag", bus.mag_out, h.mag);
                        chk("stall_hold_pix", bus.pix_out, h.pix);
                    end else begin
                        chk("stall_queue_empty", 0, 1);
                    end
                end
                bp_mode = 0;
            end
        join
        idle(8);

        // Alternating modes under random backpressure.
        bp_mode = 1;
        for (int k = 0; k < 12; k++)
            send(rand_win(), 2'(k % 3), GW'($urandom_range(0, 600)));
        bus.in_valid = 1'b0;

        // Fully random traffic with gaps.
        for (int k = 0; k < 40; k++) begin
            send(rand_win(), 2'($urandom_range(0, 3)), GW'($urandom_range(0, 700)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        bp_mode = 0;
        idle(10);

        // Clear coincident with a counting transfer.
        send(mkwin(10, 10, 10, 30, 30, 30, 50, 50, 50), 2'b10, GW'(0));
        bus.in_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            #1;
            if (bus.out_valid) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (found) begin
            bus.cnt_clr = 1'b1;
            @(posedge clk);
            #1;
            bus.cnt_clr = 1'b0;
            chk("clr_wins", bus.edge_cnt, 0);
        end else begin
            chk("clr_timeout", 0, 1);
        end
        idle(4);

        // Asynchronous reset with three windows in flight.
        send(rand_win(), 2'b10, GW'(0));
        send(rand_win(), 2'b10, GW'(0));
        send(rand_win(), 2'b10, GW'(0));
        bus.in_valid = 1'b0;
        n_rst = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_gx", bus.gx_out, 0);
        chk("midrst_mag", bus.mag_out, 0);
        chk("midrst_pix", bus.pix_out, 0);
        chk("midrst_cnt", bus.edge_cnt, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        #1;
        chk("midrst_in_ready", bus.in_ready, 1);
        idle(6);
        send(mkwin(0, 128, 255, 0, 128, 255, 0, 128, 255), 2'b11, GW'(1000));
        bus.in_valid = 1'b0;

        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
